// File: rtl/apb_dual_master_arb.sv
// apb_dual_master_arb: round-robin share of one APB master port between two
// requesters, with slave decode on paddr[AW-1] and a wait-state timeout.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   req_valid/write/addr/wdata   per-requester request (req0 in low slice)
//   req_ack, rsp_done     per-requester one-cycle pulses
//   rsp_rdata, rsp_err    response data / error (err valid with rsp_done)
//   psel, penable, pwrite, paddr, pwdata   APB master outputs
//   prdata, pready, pslverr               per-slave APB inputs (slave0 low)
module apb_dual_master_arb #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_write,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      req_ack,
    output logic [1:0]      rsp_done,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic [1:0]      psel,
    output logic            penable,
    output logic            pwrite,
    output logic [AW-1:0]   paddr,
    output logic [DW-1:0]   pwdata,
    input  logic [2*DW-1:0] prdata,
    input  logic [1:0]      pready,
    input  logic [1:0]      pslverr
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state_q, state_d;

    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    ack_q, ack_d;
    logic [1:0]    done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [1:0]    psel_q, psel_d;
    logic          pen_q, pen_d;
    logic          pwr_q, pwr_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwd_q, pwd_d;

    // Arbitration result and the request it selects
    logic          gnt_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;
    logic          write_c;

    // Inputs of the currently selected slave only
    logic          rdy;
    logic          serr;
    logic [DW-1:0] rd;
    logic          tmo;

    always_comb begin
        gnt_c = 1'b0;
        unique case (1'b1)
            (req_valid == 2'b11): gnt_c = ~last_q;
            (req_valid == 2'b10): gnt_c = 1'b1;
            default:              gnt_c = 1'b0;
        endcase
    end

    assign addr_c  = gnt_c ? req_addr[2*AW-1:AW]
                           : req_addr[AW-1:0];
    assign wdata_c = gnt_c ? req_wdata[2*DW-1:DW]
                           : req_wdata[DW-1:0];
    assign write_c = gnt_c ? req_write[1] : req_write[0];

    assign rdy  = sel_q ? pready[1]  : pready[0];
    assign serr = sel_q ? pslverr[1] : pslverr[0];
    assign rd   = sel_q ? prdata[2*DW-1:DW]
                        : prdata[DW-1:0];

    // Last permitted wait cycle: the ACCESS phase lasts TIMEOUT cycles
    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    // State and output registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            psel_q  <= '0;
            pen_q   <= 1'b0;
            pwr_q   <= 1'b0;
            paddr_q <= '0;
            pwd_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            psel_q  <= psel_d;
            pen_q   <= pen_d;
            pwr_q   <= pwr_d;
            paddr_q <= paddr_d;
            pwd_q   <= pwd_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (rdy || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        gnt_d   = gnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        psel_d  = psel_q;
        pen_d   = pen_q;
        pwr_d   = pwr_q;
        paddr_d = paddr_q;
        pwd_d   = pwd_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gnt_d   = gnt_c;
                    last_d  = gnt_c;
                    sel_d   = addr_c[AW-1];
                    ack_d   = gnt_c ? 2'b10 : 2'b01;
                    psel_d  = addr_c[AW-1] ? 2'b10 : 2'b01;
                    pen_d   = 1'b0;
                    pwr_d   = write_c;
                    paddr_d = addr_c;
                    pwd_d   = wdata_c;
                end
            end
            SETUP: begin
                pen_d = 1'b1;
                cnt_d = '0;
            end
            ACCESS: begin
                if (rdy || tmo) begin
                    psel_d = '0;
                    pen_d  = 1'b0;
                    done_d = gnt_q ? 2'b10 : 2'b01;
                    // A real pready wins over a same-cycle timeout
                    err_d  = rdy ? serr : 1'b1;
                    if (rdy && !pwr_q) rdata_d = rd;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign req_ack   = ack_q;
    assign rsp_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign psel      = psel_q;
    assign penable   = pen_q;
    assign pwrite    = pwr_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwd_q;

endmodule

// File: tb/tb_apb_dual_master_arb.sv
// tb_apb_dual_master_arb: directed-vector bench for apb_dual_master_arb.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_apb_dual_master_arb;

    localparam int AW = 9;
    localparam int DW = 8;

    logic            pclk;
    logic            preset;
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ack;
    logic [1:0]      rsp_done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [1:0]      psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [2*DW-1:0] prdata;
    logic [1:0]      pready;
    logic [1:0]      pslverr;

    int npass = 0;
    int ntot  = 0;

    logic [7:0] mem0 [0:255];

    apb_dual_master_arb #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave 0 storage: completes a write on any ready ACCESS edge
    always @(posedge pclk)
        if (psel[0] && penable && pready[0] && pwrite)
            mem0[paddr[7:0]] <= pwdata;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset;
        preset = 1'b1;
        tick();
        tick();
        preset = 1'b0;
    endtask

    initial begin
        int bad;
        preset    = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = '0;
        pslverr   = '0;
        #2;
        do_reset();

        // Reset state
        chk("rst_psel", 32'(psel), 0);
        chk("rst_pen", 32'(penable), 0);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_done", 32'(rsp_done), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_paddr", 32'(paddr), 0);

        // Single write, req0 -> slave 0, zero waits
        req_valid      = 2'b01;
        req_write      = 2'b01;
        req_addr[8:0]  = 9'h005;
        req_wdata[7:0] = 8'hA5;
        pready         = 2'b01;
        tick();
        chk("w_ack", 32'(req_ack), 32'h1);
        chk("w_psel0", 32'(psel), 32'h1);
        chk("w_pen0", 32'(penable), 0);
        chk("w_paddr", 32'(paddr), 32'h005);
        chk("w_pwrite", 32'(pwrite), 1);
        chk("w_pwdata", 32'(pwdata), 32'hA5);
        req_valid = 2'b00;
        tick();
        chk("w_psel1", 32'(psel), 32'h1);
        chk("w_pen1", 32'(penable), 1);
        chk("w_ack1", 32'(req_ack), 0);
        tick();
        chk("w_done", 32'(rsp_done), 32'h1);
        chk("w_err", 32'(rsp_err), 0);
        chk("w_psel2", 32'(psel), 0);
        chk("w_pen2", 32'(penable), 0);
        tick();
        chk("w_done_end", 32'(rsp_done), 0);
        chk("w_mem", 32'(mem0[5]), 32'hA5);

        // Read, req1 -> slave 1, two wait states
        pready          = 2'b00;
        prdata[15:8]    = 8'h3C;
        req_valid       = 2'b10;
        req_write       = 2'b00;
        req_addr[17:9]  = 9'h105;
        tick();
        chk("r_ack", 32'(req_ack), 32'h2);
        chk("r_psel", 32'(psel), 32'h2);
        chk("r_paddr", 32'(paddr), 32'h105);
        chk("r_pwrite", 32'(pwrite), 0);
        req_valid = 2'b00;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!(penable === 1'b1 && rsp_done === 2'b00
                  && psel === 2'b10)) bad++;
        end
        chk("r_wait", 32'(bad), 0);
        pready = 2'b10;
        tick();
        chk("r_done", 32'(rsp_done), 32'h2);
        chk("r_rdata", 32'(rsp_rdata), 32'h3C);
        chk("r_err", 32'(rsp_err), 0);
        chk("r_pen_off", 32'(penable), 0);
        pready = 2'b00;

        // Both requesters held: grants alternate 0,1,0,1
        do_reset();
        pready          = 2'b11;
        req_valid       = 2'b11;
        req_write       = 2'b11;
        req_addr[8:0]   = 9'h010;
        req_addr[17:9]  = 9'h120;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp1h;
            exp1h = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk($sformatf("rr_ack%0d", k), 32'(req_ack), 32'(exp1h));
            chk($sformatf("rr_psel%0d", k), 32'(psel), 32'(exp1h));
            tick();
            tick();
            chk($sformatf("rr_done%0d", k), 32'(rsp_done), 32'(exp1h));
        end
        req_valid = 2'b00;

        // Read with pslverr on the selected slave
        prdata[7:0]    = 8'h5A;
        pslverr        = 2'b01;
        pready         = 2'b01;
        req_valid      = 2'b01;
        req_write      = 2'b00;
        req_addr[8:0]  = 9'h00A;
        tick();
        chk("se_ack", 32'(req_ack), 32'h1);
        req_valid = 2'b00;
        tick();
        tick();
        chk("se_done", 32'(rsp_done), 32'h1);
        chk("se_err", 32'(rsp_err), 1);
        chk("se_rdata", 32'(rsp_rdata), 32'h5A);
        tick();
        chk("se_err_low", 32'(rsp_err), 0);

        // pslverr only on the unselected slave
        pslverr        = 2'b10;
        req_valid      = 2'b01;
        req_write      = 2'b01;
        req_addr[8:0]  = 9'h00B;
        req_wdata[7:0] = 8'h11;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        chk("ue_done", 32'(rsp_done), 32'h1);
        chk("ue_err", 32'(rsp_err), 0);
        chk("ue_rdata", 32'(rsp_rdata), 32'h5A);
        pslverr = 2'b00;

        // Timeout on slave 1; slave 0 ready must be ignored
        pready          = 2'b01;
        prdata[15:8]    = 8'hEE;
        req_valid       = 2'b10;
        req_write       = 2'b00;
        req_addr[17:9]  = 9'h1FF;
        tick();
        chk("to_ack", 32'(req_ack), 32'h2);
        req_valid = 2'b00;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!(penable === 1'b1 && rsp_done === 2'b00)) bad++;
        end
        chk("to_wait", 32'(bad), 0);
        tick();
        chk("to_done", 32'(rsp_done), 32'h2);
        chk("to_err", 32'(rsp_err), 1);
        chk("to_rdata", 32'(rsp_rdata), 32'h5A);
        chk("to_psel", 32'(psel), 0);
        pready = 2'b00;

        // Reset during ACCESS of a req0 transfer
        req_valid      = 2'b01;
        req_write      = 2'b01;
        req_addr[8:0]  = 9'h003;
        tick();
        chk("ra_ack", 32'(req_ack), 32'h1);
        req_valid = 2'b00;
        tick();
        tick();
        chk("ra_pen", 32'(penable), 1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("ra_psel", 32'(psel), 0);
        chk("ra_pen_off", 32'(penable), 0);
        chk("ra_done", 32'(rsp_done), 0);
        req_valid = 2'b11;
        tick();
        chk("ra_first", 32'(req_ack), 32'h1);
        req_valid = 2'b00;
        pready    = 2'b11;
        tick();
        tick();
        chk("ra_done2", 32'(rsp_done), 32'h1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/apb_dual_master_arb.md
Name: apb_dual_master_arb

Overview:
- Shares one APB master port between two requesters (req0, req1) and decodes each transfer to one of two APB slaves.
- Round-robin arbitration selects the requester; an IDLE/SETUP/ACCESS state machine sequences the APB protocol.
- A wait-state timeout prevents bus lock-up.
- Sits between the test/host-side request agents and the two apb_slave instances.

Parameters:
- AW, 9, address width; paddr[AW-1] selects the slave (0 -> slave 0, 1 -> slave 1).
- DW, 8, data width.
- TIMEOUT, 16, maximum ACCESS cycles without pready before an error termination (>=2).

Ports:
- pclk  in  1  APB clock, all logic on rising edge.
- preset  in  1  synchronous reset, active-high.
- req_valid  in  2  per-requester transfer request; held until req_ack.
- req_write  in  2  per-requester direction (1 = write, 0 = read).
- req_addr  in  2*AW  packed addresses, req0 in [AW-1:0].
- req_wdata  in  2*DW  packed write data, req0 in [DW-1:0].
- req_ack  out  2  one-cycle pulse: request accepted.
- rsp_done  out  2  one-cycle pulse: transfer complete.
- rsp_rdata  out  DW  read data of the last completed read.
- rsp_err  out  1  valid with rsp_done; 1 = pslverr or timeout.
- psel  out  2  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  2*DW  packed slave read data, slave 0 in [DW-1:0].
- pready  in  2  per-slave ready.
- pslverr  in  2  per-slave error.

Behaviour:
- Reset (preset=1 at an edge): state IDLE; every output 0; round-robin pointer last=1, so req0 wins first; wait counter 0. Reset mid-transfer abandons the transfer with no rsp_done, and psel/penable drop at that edge.
- All outputs are registered.
- IDLE: req_valid is sampled only in this state.
  - One requester valid: grant it.
  - Both valid: grant the requester other than last.
  - On grant, at that edge: latch addr, wdata and write onto paddr, pwdata and pwrite; set sel = addr[AW-1]; psel[sel]=1, penable=0; req_ack[gnt] pulses for 1 cycle; last=gnt; go to SETUP.
  - No request: outputs stay idle.
- SETUP: one cycle. At the next edge penable=1, wait counter=0, go to ACCESS.
- ACCESS: only pready[sel] and pslverr[sel] are observed; the unselected slave's inputs are ignored.
  - pready[sel]=1 at an edge: psel=0, penable=0; rsp_done[gnt] pulses; rsp_err=pslverr[sel]; if read, rsp_rdata=prdata[sel], else rsp_rdata holds; go to IDLE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 with pready low: terminate exactly as above but with rsp_err=1 and rsp_rdata unchanged.
- rsp_err is 0 whenever rsp_done is 0.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS and hold their last values in IDLE.
- Latency with zero wait states:
  - valid sampled at edge E0;
  - SETUP registered at E0;
  - ACCESS at E1;
  - rsp_done at E2.
  - Minimum three cycles per transfer, one idle cycle between transfers.
- Requester rule: deassert req_valid (or present the next request) in the cycle req_ack is seen. A request still valid when IDLE is next entered is a new transfer.
- Full address (including bit AW-1) is driven on paddr.

Test Plan:
- Single write, req0 addr=0x005 data=0xA5, pready[0]=1 immediately -> psel=01 for 2 cycles, penable high 1 cycle, rsp_done=01 two cycles after ack, rsp_err=0; slave 0 holds 0xA5.
- Read, req1 addr=0x105, slave 1 prdata=0x3C, two wait states -> psel=10, penable high 3 cycles, rsp_done=10, rsp_rdata=0x3C.
- Both requesters valid at the same edge after reset -> req0 granted first; with both still pending at the next IDLE, req1 granted; the grant order alternates 0,1,0,1.
- pready[sel] held low, TIMEOUT=16 -> termination after 16 ACCESS cycles with rsp_done pulse, rsp_err=1, rsp_rdata unchanged.
- pslverr[0]=1 with pready[0]=1 on a read -> rsp_err=1 and rsp_rdata updated; pslverr on the unselected slave -> rsp_err=0.
- preset asserted during ACCESS -> next edge: psel=0, penable=0, no rsp_done; the next request goes to req0 first.
